// File: rtl/result_uart_tx.sv
// UART 8N1 transmitter for the classifier result byte, with a one-cycle tx_done handshake back to the result layer.
// Optional ASCII encoding of the class index is enabled by defining RESULT_UART_ASCII_EN.
module result_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned CNT_W        = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rd,
  input  logic [7:0] din,
  output logic       TX,
  output logic       tx_done,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [2:0]       bit_cnt, bit_nxt;
  logic [7:0]       shift, shift_nxt;
  logic             tx_nxt, done_nxt;
  logic             armed, armed_nxt;
  logic             at_last;

  function automatic logic [7:0] encode(input logic [7:0] d);
`ifdef RESULT_UART_ASCII_EN
    if (d[3:0] <= 4'd9) return 8'h30 + {4'h0, d[3:0]};
    else                return 8'h3F;
`else
    return d;
`endif
  endfunction

  assign at_last = (cnt == LAST);
  assign busy    = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_cnt <= '0;
      shift   <= '0;
      TX      <= 1'b1;
      tx_done <= 1'b0;
      armed   <= 1'b1;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      bit_cnt <= bit_nxt;
      shift   <= shift_nxt;
      TX      <= tx_nxt;
      tx_done <= done_nxt;
      armed   <= armed_nxt;
    end
  end

  // TX is registered, so each transition loads the level of the bit that follows it.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    bit_nxt   = bit_cnt;
    shift_nxt = shift;
    tx_nxt    = TX;
    done_nxt  = 1'b0;
    armed_nxt = armed;
    case (state)
      IDLE: begin
        tx_nxt = 1'b1;
        if (!rd) begin
          armed_nxt = 1'b1;
        end else if (armed) begin
          shift_nxt = encode(din);
          armed_nxt = 1'b0;
          cnt_nxt   = '0;
          tx_nxt    = 1'b0;
          state_nxt = START;
        end
      end
      START: begin
        if (at_last) begin
          cnt_nxt   = '0;
          bit_nxt   = '0;
          tx_nxt    = shift[0];
          state_nxt = DATA;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      DATA: begin
        if (at_last) begin
          cnt_nxt   = '0;
          shift_nxt = {1'b0, shift[7:1]};
          bit_nxt   = bit_cnt + 1'b1;
          if (bit_cnt == 3'd7) begin
            tx_nxt    = 1'b1;
            state_nxt = STOP;
          end else begin
            tx_nxt = shift[1];
          end
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      STOP: begin
        if (at_last) begin
          cnt_nxt   = '0;
          tx_nxt    = 1'b1;
          done_nxt  = 1'b1;
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule
